sram_readback: RTL and testbench

Read-side SRAM port server for the 8-bit external SRAM holding the downloaded bitmap. It serves two readers from one clock domain: 32-bit pixel-word fetches for the video path, using a toggle handshake, and single-byte readback for the data_io upload path, driving `ioctl_din`. It is the read counterpart of the download write path. It owns the SRAM address bus only while no download is in progress; the top level multiplexes its `sram_addr` with the writer's.

---
 rtl/sram_readback.sv | 87 ++++++++
 tb/tb_sram_readback.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_readback.sv
// sram_readback: read-side SRAM server for video word fetches and data_io upload byte readback
module sram_readback #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_CYCLES = 1,
  parameter int UP_BASE     = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [31:0]       vid_q,
  output logic              vid_ack,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              up_valid,
  output logic              up_overrun,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_we_n,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, VID, UP} state_t;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [1:0] idx;
  logic [ADDR_W-1:0] up_addr;
  logic up_pend, upload_d, vid_pend, take_up, last, unused_bits;
  assign vid_pend = vid_req != vid_ack;
  assign take_up = state == IDLE && !vid_pend && up_pend && ioctl_upload;
  assign last = cnt == 3'(WAIT_CYCLES);
  assign busy = state != IDLE;
  assign sram_we_n = 1'b1;
  assign unused_bits = ^{ioctl_addr[24:ADDR_W], vid_addr[1:0]};
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = vid_pend ? VID : take_up ? UP : IDLE;
    else if (last && (state == UP || idx == 2'd3))
      state_n = IDLE;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      vid_q      <= '0;
      vid_ack    <= 1'b0;
      ioctl_din  <= '0;
      up_valid   <= 1'b0;
      up_overrun <= 1'b0;
      up_addr    <= '0;
      up_pend    <= 1'b0;
      upload_d   <= 1'b0;
      sram_addr  <= '0;
    end else begin
      state    <= state_n;
      up_valid <= 1'b0;
      upload_d <= ioctl_upload;
      cnt      <= (state == IDLE || last) ? 3'd0 : cnt + 3'd1;
      if (state == IDLE) begin
        idx <= 2'd0;
        if (vid_pend) sram_addr <= {vid_addr[ADDR_W-1:2], 2'b00};
        else if (take_up) sram_addr <= up_addr;
      end
      if (state == VID && last) begin
        vid_q[{~idx, 3'b000} +: 8] <= sram_dq_i;
        idx            <= idx + 2'd1;
        sram_addr[1:0] <= idx + 2'd1;
        if (idx == 2'd3) vid_ack <= vid_req;
      end
      if (state == UP && last) begin
        ioctl_din <= sram_dq_i;
        up_valid  <= 1'b1;
      end
      if (take_up || !ioctl_upload) up_pend <= 1'b0;
      if (ioctl_upload && !upload_d) up_overrun <= 1'b0;
      // A new strobe always wins: the latest address replaces any unserved one
      if (ioctl_rd && ioctl_upload) begin
        up_addr <= ioctl_addr[ADDR_W-1:0] + ADDR_W'(UP_BASE);
        up_pend <= 1'b1;
        if (up_pend) up_overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sram_readback.sv
// tb_sram_readback: table, corner-case and random checks of sram_readback against a memory model
module tb_sram_readback;
  localparam int WAIT = 1;
  localparam int P = WAIT + 1;
  localparam int BASE = 'h7FFFF;
  logic clk, reset, vid_req, vid_ack, ioctl_upload, ioctl_rd, up_valid, up_overrun, sram_we_n, busy;
  logic [18:0] vid_addr, sram_addr;
  logic [31:0] vid_q;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_din, sram_dq_i;
  logic [7:0] mem [0:(1<<19)-1];
  int vectors = 0, miscompares = 0;
  int ack_tog = 0, upv_cnt = 0;
  logic ack_q = 1'b0;
  sram_readback #(.ADDR_W(19), .WAIT_CYCLES(WAIT), .UP_BASE(BASE)) dut (
    .clk_sys(clk), .reset(reset), .vid_req(vid_req), .vid_addr(vid_addr), .vid_q(vid_q),
    .vid_ack(vid_ack), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .up_valid(up_valid), .up_overrun(up_overrun), .sram_addr(sram_addr),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .busy(busy)
  );
  assign sram_dq_i = mem[sram_addr];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    upv_cnt += int'(up_valid);
    if (vid_ack !== ack_q) ack_tog++;
    ack_q = vid_ack;
  end
  typedef struct {bit up; logic [24:0] addr; logic [31:0] exp; int lat;} vec_t;
  vec_t tbl[6];
  function automatic logic [31:0] ref_word(input logic [18:0] a);
    logic [18:0] b = {a[18:2], 2'b00};
    return {mem[b], mem[b + 19'd1], mem[b + 19'd2], mem[b + 19'd3]};
  endfunction
  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    logic [18:0] x = a[18:0] + 19'(BASE);
    return mem[x];
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input logic [18:0] a, output int lat);
    int bad = 0;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (vid_ack == vid_req) break;
      if (sram_addr !== {a[18:2], 2'(lat / P)} || busy !== 1'b1) bad++;
      @(posedge clk);
      lat++;
    end
    chk("vid_addr_seq", bad, 0);
  endtask
  task automatic do_vid(input logic [18:0] a, output int lat, output logic [31:0] q);
    tick();
    vid_addr = a;
    vid_req = ~vid_req;
    wait_ack(a, lat);
    q = vid_q;
  endtask
  task automatic do_up(input logic [24:0] a, output int lat, output logic [7:0] d);
    tick();
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    @(posedge clk);
    #1 ioctl_rd = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (up_valid) break;
      @(posedge clk);
      lat++;
    end
    d = ioctl_din;
  endtask
  initial begin
    int lat, al, ul, t0, u0;
    logic [31:0] q;
    logic [7:0] d;
    logic [18:0] ra;
    logic [24:0] ua;
    for (int i = 0; i < (1 << 19); i++) mem[i] = 8'($urandom);
    {mem['h100], mem['h101], mem['h102], mem['h103]} = 32'h11223344;
    {mem['h7FFFC], mem['h7FFFD], mem['h7FFFE], mem['h7FFFF]} = 32'hA1B2C3D4;
    {mem[0], mem[1], mem[2], mem[3]} = 32'hE7010203;
    mem['h0ABCD] = 8'h5A;
    tbl[0] = '{1'b0, 25'h0000102, 32'h11223344, 4 * P};
    tbl[1] = '{1'b1, 25'h010ABCE, 32'h0000005A, 1 + P};
    tbl[2] = '{1'b0, 25'h007FFFF, 32'hA1B2C3D4, 4 * P};
    tbl[3] = '{1'b1, 25'h0000001, 32'h000000E7, 1 + P};
    tbl[4] = '{1'b0, 25'h0000000, 32'hE7010203, 4 * P};
    tbl[5] = '{1'b1, 25'h0000002, 32'h00000001, 1 + P};
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0; ioctl_upload = 1'b1; ioctl_rd = 1'b0; ioctl_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vid_q", vid_q, 0);
    chk("rst_vid_ack", 32'(vid_ack), 0);
    chk("rst_din", 32'(ioctl_din), 0);
    chk("rst_valid_ovr", {up_valid, up_overrun}, 0);
    chk("rst_sram_addr", 32'(sram_addr), 0);
    chk("rst_busy_we", {busy, sram_we_n}, 32'h1);
    tick();
    reset = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].up) begin
        do_up(tbl[i].addr, lat, d);
        q = {24'h0, d};
      end else do_vid(tbl[i].addr[18:0], lat, q);
      chk($sformatf("tbl%0d_data", i), q, tbl[i].exp);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
    end
    chk("tbl_overrun", 32'(up_overrun), 0);
    // contention: strobe and video toggle captured on the same edge
    tick();
    t0 = ack_tog; u0 = upv_cnt;
    vid_addr = 19'h200; vid_req = ~vid_req; ioctl_addr = 25'h4; ioctl_rd = 1'b1;
    @(posedge clk);
    #1 ioctl_rd = 1'b0;
    lat = 0; al = -1; ul = -1; q = '0;
    while (lat < 40) begin
      @(negedge clk);
      if (vid_ack == vid_req && al < 0) begin al = lat; q = vid_q; end
      if (up_valid) ul = lat;
      if (ul >= 0) break;
      @(posedge clk);
      lat++;
    end
    repeat (5) @(negedge clk);
    #1;
    chk("cont_ack_lat", al, 4 * P);
    chk("cont_word", q, ref_word(19'h200));
    chk("cont_up_lat", ul, 5 * P + 1);
    chk("cont_din", 32'(ioctl_din), 32'(ref_byte(25'h4)));
    chk("cont_ack_toggles", ack_tog - t0, 1);
    chk("cont_valid_pulses", upv_cnt - u0, 1);
    // overrun: two strobes while a fetch holds the bus, latest address wins
    tick();
    u0 = upv_cnt;
    vid_addr = 19'h300; vid_req = ~vid_req;
    tick(); ioctl_addr = 25'h1; ioctl_rd = 1'b1;
    tick(); ioctl_rd = 1'b0;
    tick(); ioctl_addr = 25'h2; ioctl_rd = 1'b1;
    tick(); ioctl_rd = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    chk("ovr_pulses", upv_cnt - u0, 1);
    chk("ovr_din", 32'(ioctl_din), 32'h01);
    chk("ovr_flag", 32'(up_overrun), 1);
    tick(); ioctl_upload = 1'b0;
    tick();
    @(negedge clk);
    chk("ovr_hold_low", 32'(up_overrun), 1);
    tick(); ioctl_upload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ovr_clear_rise", 32'(up_overrun), 0);
    // reset on the third clock of a fetch, then the still-pending request restarts
    tick(); vid_req = 1'b0; reset = 1'b1;
    tick(); tick(); reset = 1'b0;
    tick(); vid_addr = 19'h104; vid_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ack", 32'(vid_ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr_q", {13'h0, sram_addr} | vid_q | 32'(ioctl_din), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ack(19'h104, lat);
    chk("mid_rst_lat", lat, 4 * P);
    chk("mid_rst_word", vid_q, ref_word(19'h104));
    // upload abort: strobe left pending behind a fetch, then upload drops
    tick();
    u0 = upv_cnt; d = ioctl_din;
    vid_addr = 19'h400; vid_req = ~vid_req;
    tick(); ioctl_addr = 25'h55; ioctl_rd = 1'b1;
    tick(); ioctl_rd = 1'b0;
    tick(); ioctl_upload = 1'b0;
    repeat (20) @(posedge clk);
    #1 ioctl_upload = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort_pulses", upv_cnt - u0, 0);
    chk("abort_din", 32'(ioctl_din), 32'(d));
    chk("abort_busy", 32'(busy), 0);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 1) == 1) begin
        ua = 25'($urandom);
        do_up(ua, lat, d);
        chk($sformatf("rnd%0d_byte", i), 32'(d), 32'(ref_byte(ua)));
        chk($sformatf("rnd%0d_lat", i), lat, 1 + P);
      end else begin
        ra = 19'($urandom);
        do_vid(ra, lat, q);
        chk($sformatf("rnd%0d_word", i), q, ref_word(ra));
        chk($sformatf("rnd%0d_lat", i), lat, 4 * P);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
